conv_sequencer: RTL
===================

# conv_sequencer

Control and streaming front-end for the 3x3 convolver datapath. It loads the nine filter taps and streams one image plane, pixel by pixel, into the line buffer. It generates the line-buffer, filter-buffer and MAC enables, masks windows that straddle a row edge, and delays the enable to produce an output-valid that is aligned with the MAC result. It sits directly upstream of the convolver and drives every one of its control and data inputs.

## Interface
- ADDR_W, 8, width of row_length / num_rows and the internal column/row counters
- WID_LINE, 16, pixel word width
- WID_FILTER, 16, filter tap width
- MAC_LAT, 1, cycles from mac_enable high to the matching output_mac (≥1)

- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin one plane
- row_length  in  ADDR_W  plane width L; captured on an accepted start
- num_rows  in  ADDR_W  plane height H; captured on an accepted start
- filt_valid / filt_ready  in / out  1  filter tap handshake
- filt_data  in  WID_FILTER  filter tap; taps arrive in order 1..9
- pix_valid / pix_ready  in / out  1  pixel handshake
- pix_data  in  WID_LINE  pixel; raster order, row-major
- line_buffer_reset  out  1  clears the line buffer
- row_length_o  out  ADDR_W  registered copy of captured L
- shifting_filter  out  1  filter buffer shift
- input_filter  out  WID_FILTER  tap being shifted
- shifting_line  out  1  line buffer shift
- input_line  out  WID_LINE  pixel being shifted
- mac_enable  out  1  the current window is valid; compute
- out_valid  out  1  output_mac is valid this cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at the end of the plane
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- State machine: IDLE → CLEAR → LOAD_FILT → STREAM → DRAIN → DONE → IDLE.
- IDLE:
  - start with L≥3 and H≥3 captures L and H and moves to CLEAR.
  - start with L<3 or H<3 pulses cfg_err and stays in IDLE.
  - start in any other state is ignored.
- CLEAR: line_buffer_reset high for exactly 1 cycle, then LOAD_FILT.
- LOAD_FILT:
  - filt_ready=1.
  - Each filt_valid&filt_ready beat drives shifting_filter=1 and input_filter=filt_data in the same cycle.
  - After the 9th beat, move to STREAM.
- STREAM:
  - pix_ready=1.
  - Each accepted beat drives shifting_line=1 and input_line=pix_data in the same cycle, and advances the column counter c (0..L-1, wraps to 0) and the row counter r.
  - mac_enable is registered: it is high the cycle after accepting the pixel at (r,c) if r≥2 and c≥2.
  - The pixel at (H-1, L-1) moves the FSM to DRAIN.
- DRAIN: waits until the last mac_enable has produced out_valid (MAC_LAT cycles), then moves to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- out_valid is mac_enable delayed MAC_LAT cycles through a shift register.
- Output count per plane is (L-2)*(H-2).
- Counters are ADDR_W wide and no arithmetic overflows for L,H ≤ 2^ADDR_W-1.
- Stalls (pix_valid=0) insert gaps; windows and alignment are unaffected.

## Timing
- Reset values (rst low, asynchronous): state=IDLE; all outputs 0 (row_length_o, input_line, input_filter cleared); counters 0; out_valid pipeline cleared.
- Reset mid-plane aborts immediately: no done pulse, and in-flight out_valid pulses are dropped.
- filt_ready and pix_ready are decoded from state (combinational); the shift strobes are combinational from the handshake.
- mac_enable follows the triggering shifting_line by 1 cycle; out_valid follows mac_enable by MAC_LAT cycles.
- Minimum plane duration, no stalls: 1 + 1 + 9 + L·H + MAC_LAT + 1 cycles from start to done.
- Back-to-back operation: start is accepted in the cycle after done.

## Configuration
- CONV_SEQ_STRIDE2_EN
  - Defined: stride-2 convolution. mac_enable additionally requires (r-2) even and (c-2) even. Output count is ceil((L-2)/2)·ceil((H-2)/2).
  - Undefined: stride 1 as described above. No stride logic is synthesised.

## Test plan
- L=5, H=5, taps 1..9, pixels 0..24, no stalls → 9 mac_enable pulses, the first one cycle after pixel 12 is accepted; 9 out_valid pulses MAC_LAT later; done 37+MAC_LAT cycles after start.
- L=6, H=6 with CONV_SEQ_STRIDE2_EN → 4 out_valid pulses, at windows (2,2),(2,4),(4,2),(4,4); without the macro → 16 pulses.
- start with L=2, H=8 → cfg_err pulse, busy stays 0, no strobes.
- pix_valid toggled on alternate cycles, L=4, H=3 → exactly 2 mac_enable pulses, after pixels 10 and 11; line_buffer_reset only in CLEAR.
- rst asserted after 5 pixels of a 5x5 plane → all outputs 0 asynchronously, no done; a new start after rst release completes normally.
- start re-pulsed during STREAM → ignored; pixel and output counts unchanged.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer -- control and streaming front-end for the 3x3 convolver datapath.
// Latency: tap/pixel strobes are combinational from the handshake; mac_enable is 1 cycle after
//          the window-completing pixel; out_valid follows mac_enable by MAC_LAT cycles.
// Backpressure: filt_ready/pix_ready are state-decoded; upstream stalls only insert gaps,
//               and the block never stalls mid-plane on its own.
//
// Optional build macro: CONV_SEQ_STRIDE2_EN selects stride-2 windows (every other row/column).
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   one-cycle plane request (honoured only in IDLE)
//   i_row_length, i_num_rows  plane width L / height H, captured on an accepted start
//   i_filt_valid/o_filt_ready, i_filt_data   filter tap stream (taps 1..9 in order)
//   i_pix_valid/o_pix_ready,   i_pix_data    pixel stream, raster order
//   o_line_buffer_reset       clears the line buffer (CLEAR state)
//   o_row_length              registered copy of captured L
//   o_shifting_filter, o_input_filter   filter buffer shift strobe and tap
//   o_shifting_line,   o_input_line     line buffer shift strobe and pixel
//   o_mac_enable              current window is complete and valid
//   o_out_valid               MAC result valid (mac_enable delayed MAC_LAT cycles)
//   o_busy, o_done, o_cfg_err status: not-IDLE, end-of-plane pulse, rejected-start pulse

module conv_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int WID_LINE   = 16,
    parameter int WID_FILTER = 16,
    parameter int MAC_LAT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_row_length,
    input  logic [ADDR_W-1:0]     i_num_rows,
    input  logic                  i_filt_valid,
    output logic                  o_filt_ready,
    input  logic [WID_FILTER-1:0] i_filt_data,
    input  logic                  i_pix_valid,
    output logic                  o_pix_ready,
    input  logic [WID_LINE-1:0]   i_pix_data,
    output logic                  o_line_buffer_reset,
    output logic [ADDR_W-1:0]     o_row_length,
    output logic                  o_shifting_filter,
    output logic [WID_FILTER-1:0] o_input_filter,
    output logic                  o_shifting_line,
    output logic [WID_LINE-1:0]   o_input_line,
    output logic                  o_mac_enable,
    output logic                  o_out_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int               DRAIN_W  = $clog2(MAC_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);
    localparam logic [ADDR_W-1:0]  ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  TWO      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0]  MIN_DIM  = ADDR_W'(3);
    localparam logic [3:0]         LAST_TAP = 4'd8;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_len;        // captured L
    logic [ADDR_W-1:0]  r_rows;       // captured H
    logic [ADDR_W-1:0]  r_col;        // column of the next pixel to be accepted
    logic [ADDR_W-1:0]  r_row;        // row of the next pixel to be accepted
    logic [3:0]         r_tap_cnt;    // taps accepted so far in LOAD
    logic [DRAIN_W-1:0] r_drain_cnt;  // cycles spent in DRAIN
    logic               r_mac_en;
    logic [MAC_LAT-1:0] r_ov_pipe;    // mac_enable delay line; [MAC_LAT-1] is out_valid
    logic               r_cfg_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [2:0] w_state_nxt;
    logic       w_start_ok;
    logic       w_start_bad;
    logic       w_filt_acc;
    logic       w_pix_acc;
    logic       w_col_last;
    logic       w_row_last;
    logic       w_last_pix;
    logic       w_win_ok;
    logic       w_drain_done;

    assign w_start_ok   = (r_state == S_IDLE) && i_start &&
                          (i_row_length >= MIN_DIM) && (i_num_rows >= MIN_DIM);
    assign w_start_bad  = (r_state == S_IDLE) && i_start &&
                          ((i_row_length < MIN_DIM) || (i_num_rows < MIN_DIM));
    assign w_filt_acc   = (r_state == S_LOAD) && i_filt_valid;
    assign w_pix_acc    = (r_state == S_STREAM) && i_pix_valid;

    // L and H are at least 3 here, so L-1 / H-1 never underflow.
    assign w_col_last   = (r_col == (r_len - ONE));
    assign w_row_last   = (r_row == (r_rows - ONE));
    assign w_last_pix   = w_pix_acc && w_col_last && w_row_last;
    assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

    // A window is complete once the pixel at (r,c) lands with r>=2 and c>=2:
    // the 3x3 neighbourhood ending at that pixel is then fully inside the row.
`ifdef CONV_SEQ_STRIDE2_EN
    // Stride 2: (r-2) and (c-2) even is the same as r and c even.
    assign w_win_ok = (r_row >= TWO) && (r_col >= TWO) && !r_row[0] && !r_col[0];
`else
    assign w_win_ok = (r_row >= TWO) && (r_col >= TWO);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_filt_acc && (r_tap_cnt == LAST_TAP)) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_last_pix) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last mac_enable was raised on entry to DRAIN; MAC_LAT cycles
                // later its out_valid is out, which coincides with the DONE cycle.
                if (w_drain_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and configuration capture
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_rows  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_len  <= i_row_length;
                r_rows <= i_num_rows;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tap, pixel-position and drain counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_tap_cnt <= '0;
                r_col     <= '0;
                r_row     <= '0;
            end else begin
                if (w_filt_acc) begin
                    r_tap_cnt <= r_tap_cnt + 4'd1;
                end
                if (w_pix_acc) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + ONE;
                    end else begin
                        r_col <= r_col + ONE;
                    end
                end
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC enable, output-valid alignment and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mac_en  <= 1'b0;
            r_ov_pipe <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_mac_en     <= w_pix_acc && w_win_ok;
            r_ov_pipe[0] <= r_mac_en;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_ov_pipe[i] <= r_ov_pipe[i-1];
            end
            r_cfg_err <= w_start_bad;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_filt_ready        = (r_state == S_LOAD);
    assign o_pix_ready         = (r_state == S_STREAM);
    assign o_line_buffer_reset = (r_state == S_CLEAR);
    assign o_row_length        = r_len;

    // Data outputs are zero outside an accepted beat so the datapath sees a
    // clean bus during reset and idle periods.
    assign o_shifting_filter   = w_filt_acc;
    assign o_input_filter      = w_filt_acc ? i_filt_data : '0;
    assign o_shifting_line     = w_pix_acc;
    assign o_input_line        = w_pix_acc ? i_pix_data : '0;

    assign o_mac_enable        = r_mac_en;
    assign o_out_valid         = r_ov_pipe[MAC_LAT-1];
    assign o_busy              = (r_state != S_IDLE);
    assign o_done              = (r_state == S_DONE);
    assign o_cfg_err           = r_cfg_err;

endmodule
